mips_avalon_arbiter: RTL and testbench

//  Upstream master for the Avalon-MM memory slave. Merges the CPU instruction-fetch port (read-only)
//  and data port (read/write) onto one Avalon master. Registers every request so address, read/write,

---
 rtl/mips_avalon_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mips_avalon_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_avalon_arbiter.sv
// Merges the MIPS instruction-fetch and data ports onto one Avalon-MM master, one registered
// transaction at a time, with round-robin arbitration and a waitrequest timeout.
module mips_avalon_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RDATA, S_RESP} state_e;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;   // 1 = data port owns the current transaction
  logic             rr_q, rr_d;     // 1 = data port wins the next contention
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             i_valid_q, i_valid_d;
  logic             d_valid_q, d_valid_d;
  logic             berr_q, berr_d;

  logic d_req, both_req, pick_d;
  logic unused_addr_lsb;

  assign d_req           = d_read | d_write;
  assign both_req        = i_req & d_req;
  assign pick_d          = both_req ? rr_q : d_req;
  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    berr_d    = berr_q;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          gnt_d   = pick_d;
          tmo_d   = '0;
          state_d = S_BUS;
          if (both_req) rr_d = ~rr_q;
          if (pick_d) begin
            // A simultaneous read+write is served as a write and flagged.
            addr_d  = {d_addr[31:2], 2'b00};
            wdata_d = d_wdata;
            be_d    = d_write ? d_byteen : 4'hF;
            wr_d    = d_write;
            rd_d    = ~d_write;
            if (d_read && d_write) berr_d = 1'b1;
          end else begin
            addr_d = {i_addr[31:2], 2'b00};
            be_d   = 4'hF;
            wr_d   = 1'b0;
            rd_d   = 1'b1;
          end
        end
      end
      S_BUS: begin
        if (!avm_waitrequest) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (wr_q) begin
            d_valid_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            state_d = S_RDATA;
          end
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          // Abort: the requester still gets its completion pulse, with zero data.
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          berr_d  = 1'b1;
          state_d = S_RESP;
          if (gnt_q) begin
            d_rdata_d = '0;
            d_valid_d = 1'b1;
          end else begin
            i_rdata_d = '0;
            i_valid_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RDATA: begin
        state_d = S_RESP;
        if (gnt_q) begin
          d_rdata_d = avm_readdata;
          d_valid_d = 1'b1;
        end else begin
          i_rdata_d = avm_readdata;
          i_valid_d = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      rr_q      <= 1'b0;
      tmo_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      berr_q    <= berr_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign i_rdata        = i_rdata_q;
  assign i_valid        = i_valid_q;
  assign d_rdata        = d_rdata_q;
  assign d_valid        = d_valid_q;
  assign bus_error      = berr_q;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Randomized scoreboard bench for mips_avalon_arbiter: a behavioural Avalon slave plus a
// transaction-level model that predicts grant order, latency, read data and bus_error.
module tb_mips_avalon_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_byteen = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        bus_error;

  mips_avalon_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteen(d_byteen), .d_rdata(d_rdata), .d_valid(d_valid),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_d;
    int          vcyc;
    logic [31:0] irx;
    logic [31:0] drx;
    bit          berr;
  } sb_t;

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } slv_t;

  sb_t  sb_q[$];
  slv_t slv_q[$];

  logic [31:0] slv_mem[64];
  logic [31:0] ref_mem[64];

  bit          m_rr = 1'b0;
  bit          m_berr = 1'b0;
  logic [31:0] m_last_i = '0;
  logic [31:0] m_last_d = '0;

  // Transaction-level model: one served request, starting at the cycle it is sampled.
  task automatic model_txn(input bit is_d, input bit wr, input bit conflict,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int d, input int start,
                           output int vcyc);
    int idx;
    int lat;
    idx = int'(addr[7:2]);
    if (conflict) m_berr = 1'b1;
    if (d >= TMO) begin
      m_berr = 1'b1;
      if (is_d) m_last_d = '0; else m_last_i = '0;
      lat = TMO + 1;
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      lat = d + 2;
    end else begin
      if (is_d) m_last_d = ref_mem[idx]; else m_last_i = ref_mem[idx];
      lat = d + 3;
    end
    vcyc = start + lat;
    slv_q.push_back('{d: d, wr: wr, addr: addr, wdata: wdata, be: be});
    sb_q.push_back('{is_d: is_d, vcyc: vcyc, irx: m_last_i, drx: m_last_d, berr: m_berr});
  endtask

  task automatic do_round(input bit ui, input bit dr, input bit dw,
                          input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int di, input int dd);
    int  c0;
    int  v;
    int  v2;
    int  budget;
    bit  ud;
    bit  d_first;
    ud = dr | dw;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    c0       = cyc;
    i_req    = ui;
    i_addr   = ia;
    d_read   = dr;
    d_write  = dw;
    d_addr   = da;
    d_wdata  = wd;
    d_byteen = be;
    d_first  = ud && (!ui || m_rr);
    if (ui && ud) m_rr = ~m_rr;
    if (d_first) begin
      model_txn(1'b1, dw, dr & dw, da, wd, be, dd, c0, v);
      if (ui) model_txn(1'b0, 1'b0, 1'b0, ia, '0, 4'hF, di, v + 1, v2);
    end else begin
      model_txn(1'b0, 1'b0, 1'b0, ia, '0, 4'hF, di, c0, v);
      if (ud) model_txn(1'b1, dw, dr & dw, da, wd, be, dd, v + 1, v2);
    end
    budget = 400;
    while ((i_req || d_read || d_write) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (i_valid) begin
        i_req  = 1'b0;
        i_addr = $urandom;
      end
      if (d_valid) begin
        d_read   = 1'b0;
        d_write  = 1'b0;
        d_addr   = $urandom;
        d_wdata  = $urandom;
        d_byteen = 4'($urandom);
      end
    end
    chkb("round_done", budget > 0, 1'b1);
    i_req   = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  function automatic int rand_delay(input bit errs);
    if (errs && $urandom_range(0, 9) == 0) return int'($urandom_range(TMO, TMO + 8));
    return int'($urandom_range(0, 4));
  endfunction

  task automatic rand_round(input bit errs);
    int sel;
    bit ui;
    bit dr;
    bit dw;
    sel = int'($urandom_range(0, 2));
    ui  = (sel != 1);
    dr  = 1'b0;
    dw  = 1'b0;
    if (sel != 0) begin
      if ($urandom_range(0, 1) == 1) dw = 1'b1; else dr = 1'b1;
      if (errs && $urandom_range(0, 7) == 0) begin
        dr = 1'b1;
        dw = 1'b1;
      end
    end
    do_round(ui, dr, dw, 32'hBFC00000 | ($urandom & 32'hFF), $urandom & 32'hFF,
             $urandom, 4'($urandom), rand_delay(errs), rand_delay(errs));
  endtask

  // Behavioural Avalon slave: waitrequest per queued delay, read data one cycle after acceptance.
  bit          s_in = 1'b0;
  int          s_wl = 0;
  int          s_hi = 0;
  slv_t        s_cur;
  bit          s_pend = 1'b0;
  logic [31:0] s_word = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        s_in            = 1'b0;
        s_pend          = 1'b0;
        avm_waitrequest = 1'b0;
        continue;
      end
      avm_readdata = s_pend ? s_word : $urandom;
      s_pend       = 1'b0;
      chkb("rd_wr_exclusive", avm_read & avm_write, 1'b0);
      if (avm_read || avm_write) begin
        if (!s_in) begin
          chkb("expected_bus_txn", slv_q.size() != 0, 1'b1);
          if (slv_q.size() != 0) begin
            s_cur = slv_q.pop_front();
            chk("avm_address", avm_address, {s_cur.addr[31:2], 2'b00});
            chkb("avm_write", avm_write, s_cur.wr);
            chkb("avm_read", avm_read, !s_cur.wr);
            chk("avm_byteenable", 32'(avm_byteenable), 32'(s_cur.wr ? s_cur.be : 4'hF));
            if (s_cur.wr) chk("avm_writedata", avm_writedata, s_cur.wdata);
          end else begin
            s_cur = '{d: 0, wr: avm_write, addr: avm_address, wdata: avm_writedata,
                      be: avm_byteenable};
          end
          s_in = 1'b1;
          s_wl = s_cur.d;
          s_hi = 0;
        end else begin
          chkb("avm_fields_stable",
               (avm_address == {s_cur.addr[31:2], 2'b00}) && (avm_write == s_cur.wr) &&
               (avm_byteenable == (s_cur.wr ? s_cur.be : 4'hF)) &&
               (!s_cur.wr || avm_writedata == s_cur.wdata), 1'b1);
        end
        s_hi++;
        if (s_wl > 0) begin
          avm_waitrequest = 1'b1;
          s_wl--;
        end else begin
          avm_waitrequest = 1'b0;
          s_in = 1'b0;
          chkb("accept_before_timeout", s_cur.d < TMO, 1'b1);
          chk("bus_cycles", s_hi, s_cur.d + 1);
          if (avm_write) begin
            for (int b = 0; b < 4; b++)
              if (avm_byteenable[b]) slv_mem[avm_address[7:2]][8*b +: 8] = avm_writedata[8*b +: 8];
          end else begin
            s_pend = 1'b1;
            s_word = slv_mem[avm_address[7:2]];
          end
        end
      end else begin
        if (s_in) begin
          s_in = 1'b0;
          chkb("abort_expected", s_cur.d >= TMO, 1'b1);
          chk("abort_bus_cycles", s_hi, TMO);
        end
        avm_waitrequest = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops the scoreboard on every completion pulse.
  bit  mon_prev = 1'b0;
  sb_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_prev = 1'b0;
        continue;
      end
      if (i_valid || d_valid) begin
        chkb("single_port_valid", i_valid & d_valid, 1'b0);
        chkb("valid_one_cycle", mon_prev, 1'b0);
        chkb("valid_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chkb("valid_port", d_valid, mon_e.is_d);
          chk("valid_cycle", cyc, mon_e.vcyc);
          chk("i_rdata", i_rdata, mon_e.irx);
          chk("d_rdata", d_rdata, mon_e.drx);
          chkb("bus_error", bus_error, mon_e.berr);
        end
      end
      mon_prev = i_valid | d_valid;
    end
  end

  task automatic reset_mid_bus();
    int budget;
    budget = 50;
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 32'hBFC00040;
    slv_q.push_back('{d: 6, wr: 1'b0, addr: 32'hBFC00040, wdata: '0, be: 4'hF});
    while (!avm_read && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chkb("rst_reached_bus", avm_read, 1'b1);
    #2 reset = 1'b1;
    #1;
    chkb("rst_async_avm_read", avm_read, 1'b0);
    chkb("rst_async_avm_write", avm_write, 1'b0);
    chkb("rst_async_i_valid", i_valid, 1'b0);
    chkb("rst_async_d_valid", d_valid, 1'b0);
    chk("rst_async_avm_address", avm_address, '0);
    chk("rst_async_byteenable", 32'(avm_byteenable), '0);
    chkb("rst_async_bus_error", bus_error, 1'b0);
    chk("rst_async_i_rdata", i_rdata, '0);
    i_req = 1'b0;
    slv_q.delete();
    sb_q.delete();
    m_rr     = 1'b0;
    m_berr   = 1'b0;
    m_last_i = '0;
    m_last_d = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chkb("no_valid_after_reset", i_valid | d_valid, 1'b0);
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      slv_mem[k] = $urandom;
      ref_mem[k] = slv_mem[k];
    end
    slv_mem[4] = 32'h11223344;
    ref_mem[4] = 32'h11223344;

    repeat (3) @(posedge clk);
    #1;
    chkb("reset_avm_read", avm_read, 1'b0);
    chkb("reset_avm_write", avm_write, 1'b0);
    chkb("reset_i_valid", i_valid, 1'b0);
    chkb("reset_d_valid", d_valid, 1'b0);
    chk("reset_avm_address", avm_address, '0);
    chk("reset_avm_writedata", avm_writedata, '0);
    chk("reset_avm_byteenable", 32'(avm_byteenable), '0);
    chk("reset_i_rdata", i_rdata, '0);
    chk("reset_d_rdata", d_rdata, '0);
    chkb("reset_bus_error", bus_error, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Instruction read with two waitrequest cycles.
    do_round(1'b1, 1'b0, 1'b0, 32'hBFC00000, '0, '0, 4'h0, 2, 0);
    // Partial data write merges into the stored word.
    do_round(1'b0, 1'b0, 1'b1, '0, 32'h10, 32'hAABBCCDD, 4'b0011, 0, 3);
    chk("word_0x10_after_write", slv_mem[4], 32'h1122CCDD);
    // Contention twice: instr first, then data first.
    do_round(1'b1, 1'b1, 1'b0, 32'hBFC00008, 32'h20, '0, 4'h0, 1, 2);
    do_round(1'b1, 1'b1, 1'b0, 32'hBFC0000C, 32'h24, '0, 4'h0, 0, 1);
    // Zero-wait data read and an unaligned fetch address.
    do_round(1'b0, 1'b1, 1'b0, '0, 32'h4, '0, 4'h0, 0, 0);
    do_round(1'b1, 1'b0, 1'b0, 32'hBFC00002, '0, '0, 4'h0, 1, 0);
    // Longest wait that still completes.
    do_round(1'b1, 1'b0, 1'b0, 32'hBFC00010, '0, '0, 4'h0, TMO - 1, 0);

    repeat (40) rand_round(1'b0);

    // Timeout, then the next request is still served.
    do_round(1'b1, 1'b0, 1'b0, 32'hBFC00014, '0, '0, 4'h0, 40, 0);
    do_round(1'b1, 1'b0, 1'b0, 32'hBFC00018, '0, '0, 4'h0, 1, 0);
    do_round(1'b0, 1'b0, 1'b1, '0, 32'h30, 32'h12345678, 4'hF, 0, TMO);

    repeat (60) rand_round(1'b1);

    reset_mid_bus();
    do_round(1'b1, 1'b0, 1'b0, 32'hBFC00020, '0, '0, 4'h0, 2, 0);
    repeat (20) rand_round(1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("slave_queue_drained", slv_q.size(), 0);
    for (int k = 0; k < 64; k++) chk($sformatf("mem_word_%0d", k), slv_mem[k], ref_mem[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
